// File: rtl/exec_dispatch.sv
// Single-issue dispatcher: queues decoded ops, runs one at a time on a shared
// execution unit for a per-class latency, then holds the result for writeback.
module exec_dispatch #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int FPU_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [4:0]  in_rd,
  output logic        eu_en,
  output logic [3:0]  eu_op,
  output logic [31:0] eu_operand0,
  output logic [31:0] eu_operand1,
  input  logic [31:0] eu_res,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int PW     = $clog2(DEPTH);
  localparam int CNTW   = PW + 1;
  localparam int MAXLAT = (ALU_LAT > FPU_LAT) ? ALU_LAT : FPU_LAT;
  localparam int LW     = $clog2(MAXLAT + 1);

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } entry_t;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t            state_q, state_d;
  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  entry_t            iss_q, iss_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              push, pop;

  assign in_ready = (count_q < CNTW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == IDLE) && (count_q != '0);
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

  // Queue bookkeeping; a pop only ever happens from IDLE.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{op: in_op, a: in_a, b: in_b, rd: in_rd};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CNTW'(1);
    else if (pop && !push) count_d = count_q - CNTW'(1);
  end

  always_comb begin
    state_d     = state_q;
    iss_d       = iss_q;
    lat_d       = lat_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    eu_en       = 1'b0;
    eu_op       = '0;
    eu_operand0 = '0;
    eu_operand1 = '0;
    wb_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          iss_d   = mem_q[rd_ptr_q];
          lat_d   = mem_q[rd_ptr_q].op[3] ? LW'(FPU_LAT) : LW'(ALU_LAT);
          state_d = EXEC;
        end
      end
      EXEC: begin
        eu_en       = 1'b1;
        eu_op       = iss_q.op;
        eu_operand0 = iss_q.a;
        eu_operand1 = iss_q.b;
        lat_d       = lat_q - LW'(1);
        // The result is taken in the last enabled cycle.
        if (lat_q == LW'(1)) begin
          wb_data_d = eu_res;
          wb_rd_d   = iss_q.rd;
          state_d   = WB;
        end
      end
      WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      iss_q     <= '0;
      lat_q     <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      iss_q     <= iss_d;
      lat_q     <= lat_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      mem_q     <= mem_d;
    end
  end

endmodule

// File: tb/tb_exec_dispatch.sv
// Directed bench for exec_dispatch: drives and samples on the falling edge.
module tb_exec_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_rd = '0;
  logic        eu_en;
  logic [3:0]  eu_op;
  logic [31:0] eu_operand0, eu_operand1;
  logic [31:0] eu_res;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        eu_manual = 1'b1;
  logic [31:0] eu_res_man = '0;

  int tests_run = 0;
  int tests_failed = 0;

  // Execution unit model: either a value forced by the test or a + b.
  always_comb eu_res = eu_manual ? eu_res_man : (eu_operand0 + eu_operand1);

  always #5 clk = ~clk;

  exec_dispatch #(.DEPTH(4), .ALU_LAT(1), .FPU_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .eu_en(eu_en), .eu_op(eu_op), .eu_operand0(eu_operand0), .eu_operand1(eu_operand1),
    .eu_res(eu_res),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    tests_run++; if (eu_en !== 1'b0) begin tests_failed++; $display("FAIL rst_eu_en got %0b want 0", eu_en); end
    tests_run++; if (eu_op !== 4'h0) begin tests_failed++; $display("FAIL rst_eu_op got %0h want 0", eu_op); end
    tests_run++; if ({eu_operand0, eu_operand1} !== 64'h0) begin tests_failed++; $display("FAIL rst_operands got %0h/%0h want 0/0", eu_operand0, eu_operand1); end
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_wb_valid got %0b want 0", wb_valid); end
    tests_run++; if (wb_rd !== 5'd0) begin tests_failed++; $display("FAIL rst_wb_rd got %0d want 0", wb_rd); end
    tests_run++; if (wb_data !== 32'h0) begin tests_failed++; $display("FAIL rst_wb_data got %0h want 0", wb_data); end
    repeat (2) @(negedge clk);
  endtask

  // Reset is released on the same falling edge the first op is offered.
  task automatic test_alu;
    @(negedge clk);
    rst = 1'b0; wb_ready = 1'b1; eu_manual = 1'b1; eu_res_man = 32'd12;
    in_valid = 1'b1; in_op = 4'h2; in_a = 32'd5; in_b = 32'd7; in_rd = 5'd3;
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++; if (eu_en !== 1'b0) begin tests_failed++; $display("FAIL alu_pre_en got %0b want 0", eu_en); end
    @(negedge clk);
    tests_run++; if (eu_en !== 1'b1) begin tests_failed++; $display("FAIL alu_en got %0b want 1", eu_en); end
    tests_run++; if ({eu_op, eu_operand0, eu_operand1} !== {4'h2, 32'd5, 32'd7}) begin tests_failed++; $display("FAIL alu_issue got op %0h %0d/%0d want 2 5/7", eu_op, eu_operand0, eu_operand1); end
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL alu_early_wb got %0b want 0", wb_valid); end
    @(negedge clk);
    tests_run++; if (eu_en !== 1'b0 || eu_op !== 4'h0) begin tests_failed++; $display("FAIL alu_en_drop got en %0b op %0h want 0 0", eu_en, eu_op); end
    tests_run++; if (wb_valid !== 1'b1) begin tests_failed++; $display("FAIL alu_wb_valid got %0b want 1", wb_valid); end
    tests_run++; if (wb_rd !== 5'd3 || wb_data !== 32'd12) begin tests_failed++; $display("FAIL alu_wb got rd %0d data %0d want 3 12", wb_rd, wb_data); end
    @(negedge clk);
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL alu_wb_done got %0b want 0", wb_valid); end
  endtask

  task automatic test_fpu;
    logic [31:0] res_seq [3];
    res_seq[0] = 32'h11111111; res_seq[1] = 32'h22222222; res_seq[2] = 32'h40400000;
    eu_manual = 1'b1; wb_ready = 1'b1;
    in_valid = 1'b1; in_op = 4'h9; in_a = 32'h3f800000; in_b = 32'h40000000; in_rd = 5'd4;
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++; if (eu_en !== 1'b0) begin tests_failed++; $display("FAIL fpu_pre_en got %0b want 0", eu_en); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      eu_res_man = res_seq[i];
      tests_run++; if (eu_en !== 1'b1 || eu_op !== 4'h9 || eu_operand0 !== 32'h3f800000 || eu_operand1 !== 32'h40000000)
        begin tests_failed++; $display("FAIL fpu_exec_%0d got en %0b op %0h %0h/%0h want 1 9 3f800000/40000000", i, eu_en, eu_op, eu_operand0, eu_operand1); end
    end
    @(negedge clk);
    tests_run++; if (eu_en !== 1'b0) begin tests_failed++; $display("FAIL fpu_en_len got %0b want 0 after 3 cycles", eu_en); end
    tests_run++; if (wb_valid !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 32'h40400000) begin tests_failed++; $display("FAIL fpu_wb got v %0b rd %0d data %0h want 1 4 40400000", wb_valid, wb_rd, wb_data); end
    @(negedge clk);
    eu_manual = 1'b0;
  endtask

  task automatic test_backpressure;
    int sent = 0;
    int got = 0;
    wb_ready = 1'b0; eu_manual = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (sent < 6) begin
        in_valid = 1'b1; in_op = 4'h1; in_a = sent; in_b = 32'd100; in_rd = 5'(sent);
        if (in_ready) sent++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests_run++; if (sent !== 5) begin tests_failed++; $display("FAIL bp_accepted got %0d want 5", sent); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready got %0b want 0", in_ready); end
    repeat (5) @(negedge clk);
    tests_run++; if (wb_valid !== 1'b1 || wb_rd !== 5'd0 || wb_data !== 32'd100) begin tests_failed++; $display("FAIL bp_stall got v %0b rd %0d data %0d want 1 0 100", wb_valid, wb_rd, wb_data); end
    wb_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      if (wb_valid) begin
        tests_run++; if (wb_rd !== 5'(got) || wb_data !== 32'(got + 100)) begin tests_failed++; $display("FAIL bp_order_%0d got rd %0d data %0d want %0d %0d", got, wb_rd, wb_data, got, got + 100); end
        got++;
      end
      @(negedge clk);
    end
    tests_run++; if (got !== 5) begin tests_failed++; $display("FAIL bp_wb_count got %0d want 5", got); end
    repeat (3) @(negedge clk);
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_extra_wb got %0b want 0", wb_valid); end
  endtask

  task automatic test_full_boundary;
    int sent = 0;
    int got = 0;
    wb_ready = 1'b0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      if (sent < 5) begin
        in_valid = 1'b1; in_op = 4'h1; in_a = 10 + sent; in_b = 32'd0; in_rd = 5'(10 + sent);
        if (in_ready) sent++;
      end else in_valid = 1'b0;
      @(negedge clk);
    end
    tests_run++; if (wb_valid !== 1'b1 || wb_rd !== 5'd10 || in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_setup got v %0b rd %0d rdy %0b want 1 10 0", wb_valid, wb_rd, in_ready); end
    in_valid = 1'b1; in_op = 4'h1; in_a = 32'd15; in_b = 32'd0; in_rd = 5'd15; wb_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b0 || wb_valid !== 1'b0) begin tests_failed++; $display("FAIL full_idle got rdy %0b v %0b want 0 0", in_ready, wb_valid); end
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b1 || eu_en !== 1'b1) begin tests_failed++; $display("FAIL full_pop got rdy %0b en %0b want 1 1", in_ready, eu_en); end
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_refill got rdy %0b want 0", in_ready); end
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      if (wb_valid) begin
        tests_run++; if (wb_rd !== 5'(11 + got) || wb_data !== 32'(11 + got)) begin tests_failed++; $display("FAIL full_order_%0d got rd %0d data %0d want %0d", got, wb_rd, wb_data, 11 + got); end
        got++;
      end
      @(negedge clk);
    end
    tests_run++; if (got !== 5) begin tests_failed++; $display("FAIL full_wb_count got %0d want 5", got); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int quiet_bad = 0;
    bit seen = 1'b0;
    wb_ready = 1'b1; eu_manual = 1'b0;
    in_valid = 1'b1; in_op = 4'h9; in_a = 32'd1; in_b = 32'd2; in_rd = 5'd20;
    @(negedge clk);
    in_op = 4'h1; in_rd = 5'd21;
    @(negedge clk);
    in_rd = 5'd22;
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++; if (eu_en !== 1'b1 || eu_op !== 4'h9) begin tests_failed++; $display("FAIL rmid_exec got en %0b op %0h want 1 9", eu_en, eu_op); end
    #1 rst = 1'b1;
    #1;
    tests_run++; if (eu_en !== 1'b0 || in_ready !== 1'b1 || wb_valid !== 1'b0 || eu_op !== 4'h0) begin tests_failed++; $display("FAIL rmid_async got en %0b rdy %0b v %0b op %0h want 0 1 0 0", eu_en, in_ready, wb_valid, eu_op); end
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (wb_valid !== 1'b0 || eu_en !== 1'b0) quiet_bad++;
    end
    tests_run++; if (quiet_bad !== 0) begin tests_failed++; $display("FAIL rmid_discard got %0d active cycles want 0", quiet_bad); end
    in_valid = 1'b1; in_op = 4'h1; in_a = 32'd7; in_b = 32'd8; in_rd = 5'd23;
    @(negedge clk);
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      if (wb_valid) begin
        seen = 1'b1;
        tests_run++; if (wb_rd !== 5'd23 || wb_data !== 32'd15) begin tests_failed++; $display("FAIL rmid_new_wb got rd %0d data %0d want 23 15", wb_rd, wb_data); end
      end
      @(negedge clk);
    end
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL rmid_timeout got no wb_valid want 1 within 10 cycles"); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_fpu();
    test_backpressure();
    test_full_boundary();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exec_dispatch.md
EXEC_DISPATCH -- requirements
Module: exec_dispatch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of pending-op queue entries (power of two, >= 2).
REQ-002 Parameter ALU_LAT, default 1, SHALL set the cycles eu_en is held for an ALU op (op[3]=0), >= 1.
REQ-003 Parameter FPU_LAT, default 3, SHALL set the cycles eu_en is held for an FPU op (op[3]=1), >= 1.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  upstream offers a decoded op.
REQ-007 in_ready  out  1  block accepts the op this cycle.
REQ-008 in_op  in  4  op code (bit 3 selects FPU).
REQ-009 in_a, in_b  in  32 each  operands.
REQ-010 in_rd  in  5  destination register tag.
REQ-011 eu_en  out  1  enable to execution unit.
REQ-012 eu_op  out  4  op to execution unit.
REQ-013 eu_operand0, eu_operand1  out  32 each  operands to execution unit.
REQ-014 eu_res  in  32  result from execution unit.
REQ-015 wb_valid  out  1  writeback result available.
REQ-016 wb_ready  in  1  writeback consumer accepts.
REQ-017 wb_rd  out  5  tag of result; wb_data  out  32  result value.

Function
REQ-018 Queue: FIFO of {op,a,b,rd}; push on in_valid&&in_ready; in_ready SHALL equal (count<DEPTH), combinational from count.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH; push when full SHALL never occur (in_ready=0).
REQ-020 FSM states IDLE, EXEC, WB; exactly one op in flight.
REQ-021 IDLE: if count>0, SHALL pop head into issue registers, load counter with ALU_LAT or FPU_LAT per op[3], go EXEC; else stay.
REQ-022 EXEC: eu_en=1, eu_op/eu_operand0/eu_operand1 SHALL equal issue registers and remain stable; counter decrements each cycle.
REQ-023 EXEC with counter==1: SHALL capture eu_res into wb_data, issue rd into wb_rd, go WB.
REQ-024 Outside EXEC, eu_en SHALL be 0 and eu_op/eu_operand* SHALL be 0.
REQ-025 WB: wb_valid=1, wb_rd/wb_data stable; on wb_ready go IDLE; wb_valid=0 in all other states.
REQ-026 Latency: op popped at edge N drives eu_en during cycles N+1..N+LAT; wb_valid asserts cycle N+LAT+1.
REQ-027 Queue pushes SHALL continue during EXEC and WB; ordering of writebacks SHALL equal acceptance order.
REQ-028 wb_ready held low SHALL stall indefinitely with no loss; queue fills to DEPTH then deasserts in_ready.

Reset
REQ-029 rst=1 SHALL immediately force: FSM=IDLE, count=0, pointers=0, counter=0, in_ready=1, eu_en=0, eu_op=0, eu_operand*=0, wb_valid=0, wb_rd=0, wb_data=0.
REQ-030 rst mid-EXEC or mid-WB SHALL discard the in-flight op and all queued ops; no writeback of them after release.
REQ-031 First op may be accepted on the first rising edge after rst deasserts.

Verification
REQ-032 ALU op: push op=0x2,a=5,b=7,rd=3, wb_ready=1 -> eu_en high exactly 1 cycle with operands 5/7; eu_res=12 -> wb_valid next cycle, wb_rd=3, wb_data=12.
REQ-033 FPU op: push op=0x9,rd=4 -> eu_en high exactly 3 cycles; wb_data equals eu_res sampled in third cycle (0x40400000).
REQ-034 Backpressure: wb_ready=0, push 6 ops -> in_ready falls after 4 queued + 1 in flight; release wb_ready -> 5 writebacks in push order, rd 0..4.
REQ-035 Full boundary: count=4 in WB, wb_ready=1 with in_valid=1 -> next IDLE pop frees slot; push accepted only when in_ready=1, count never exceeds 4.
REQ-036 Reset mid-FPU op (second EXEC cycle) with 2 queued -> eu_en=0, in_ready=1 same cycle; no wb_valid thereafter until a new op is pushed.
